// File: rtl/vt_pkg.sv
// Shared Varshamov-Tenengolts helpers used by both the encoder and the decoder.
// This package holds the position map, the checksum width helpers and the
// parameter legality check.
package vt_pkg;

    // Positions are 1-based. Parity positions are the powers of two.
    function automatic bit is_parity_pos(input int i);
        return (i > 0) && ((i & (i - 1)) == 0);
    endfunction

    // Position of the j-th data bit (0-based j). It counts the non-power-of-two
    // positions in ascending order. The j-th one always lies below 2*j+4.
    function automatic int data_pos(input int j);
        int count;
        int result;
        count  = 0;
        result = 0;
        for (int pos = 1; pos <= 2 * j + 4; pos++) begin
            if (!is_parity_pos(pos)) begin
                if ((count == j) && (result == 0)) begin
                    result = pos;
                end
                count++;
            end
        end
        return result;
    endfunction

    // floor(log2(v)) for v >= 1.
    function automatic int floor_log2(input int v);
        int r;
        r = 0;
        for (int t = v; t > 1; t = t >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Width needed to hold the raw weighted sum, which is at most n(n+1)/2.
    function automatic int checksum_width(input int n);
        return $clog2(n * (n + 1) / 2 + 1);
    endfunction

    // Width needed to hold a residue modulo n+1.
    function automatic int syndrome_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Checks the code geometry and the residue value.
    // The data bits must fit beside the parity bits. The parity positions
    // must be able to reach every residue. The residue a must lie in 0..n.
    function automatic bit params_legal(input int n, input int k, input int a);
        int fl;
        fl = floor_log2(n);
        return (n >= 3) && (k >= 1) && (k <= n - (fl + 1)) &&
               (n + 1 <= (1 << (fl + 1))) && (a >= 0) && (a <= n);
    endfunction

endpackage

// File: rtl/vt_syndrome.sv
// VT checksum: s = (sum of i * word[i-1] for i = 1..n) mod (n+1).
// The encoder uses this block as well as the decoder.
// The modulo uses a constant divisor only. The block is purely combinational.
module vt_syndrome
    import vt_pkg::*;
#(
    parameter int n = 10
) (
    input  logic [n-1:0]                 word,
    output logic [syndrome_width(n)-1:0] s
);

    localparam int SW = checksum_width(n);
    localparam int YW = syndrome_width(n);
    localparam logic [SW-1:0] MODULUS = SW'(n + 1);

    logic [SW-1:0] raw_sum;

    // Weighted sum of set positions. Masking the weights instead of using an
    // if statement lets X on the input reach the result.
    always_comb begin
        raw_sum = '0;
        for (int i = 1; i <= n; i++) begin
            raw_sum = raw_sum + (SW'(i) & {SW{word[i-1]}});
        end
    end

    assign s = YW'(raw_sum % MODULUS);

endmodule

// File: rtl/vt_decoder.sv
// Registered single-codeword VT decoder.
// It checks the checksum of the received word against SYNDROME_VAL. It can
// repair one 1->0 error, extracts the k systematic bits, and registers the
// result, so latency is one cycle.
// Optional feature macro: VT_ASYM_CORRECT_EN (enables single 1->0 correction).
// Without the macro the block only detects errors and extracts the raw data.
module vt_decoder
    import vt_pkg::*;
#(
    parameter int k            = 5,
    parameter int n            = 10,
    parameter int SYNDROME_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] data_in,
    output logic [k-1:0] original,
    output logic         good_syndrome
);

    localparam int YW = syndrome_width(n);
    localparam logic [YW-1:0] RESIDUE = YW'(SYNDROME_VAL);

    logic [YW-1:0] s;
    logic          match;
    logic [n-1:0]  corrected;
    logic [k-1:0]  extracted;
    logic          unused_corrected;

    // Reject illegal code geometries during elaboration.
    if (!params_legal(n, k, SYNDROME_VAL)) begin : g_illegal_params
        $error("vt_decoder: illegal parameter combination n/k/SYNDROME_VAL");
    end

    vt_syndrome #(
        .n(n)
    ) u_syndrome (
        .word(data_in),
        .s   (s)
    );

    assign match = (s == RESIDUE);

`ifdef VT_ASYM_CORRECT_EN
    localparam logic [YW:0] MOD_EXT = (YW + 1)'(n + 1);

    logic [YW:0]   diff;
    logic [YW-1:0] p;

    // Compute the error position p = (a - s) mod (n+1).
    // Both a and s lie in 0..n, so one conditional subtract is enough.
    always_comb begin
        diff = {1'b0, RESIDUE} + MOD_EXT - {1'b0, s};
        if (diff >= MOD_EXT) begin
            diff = diff - MOD_EXT;
        end
        p = diff[YW-1:0];
    end

    // When the checksum is off, set position p back to 1.
    // OR-ing means a bit that is already 1 stays as it is.
    // p = 0 only occurs when s equals a, so no position is touched then.
    always_comb begin
        corrected = data_in;
        for (int i = 1; i <= n; i++) begin
            corrected[i-1] = data_in[i-1] | (~match & (p == YW'(i)));
        end
    end
`else
    assign corrected = data_in;
`endif

    // Pick the k data bits from the non-power-of-two positions.
    // Parity and spare positions are dropped here.
    for (genvar j = 0; j < k; j++) begin : g_extract
        localparam int POS = data_pos(j);
        assign extracted[j] = corrected[POS-1];
    end

    assign unused_corrected = ^corrected;

    // Output registers. Asynchronous reset clears both outputs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            original      <= '0;
            good_syndrome <= 1'b0;
        end else begin
            original      <= extracted;
            good_syndrome <= match;
        end
    end

endmodule

// File: tb/tb_vt_decoder.sv
// Scoreboard testbench for vt_decoder with n=10, k=5, a=0.
// The stimulus process pushes the expected response when it drives a word.
// The monitor process pops and compares one cycle later.
// Expected values come from spec constants or from a position-list reference
// model. The model honours VT_ASYM_CORRECT_EN in the same way as the design.
module tb_vt_decoder;

    localparam int N = 10;
    localparam int K = 5;
    localparam int A = 0;

    typedef struct packed {
        logic [K-1:0] orig;
        logic         good;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] data_in;
    logic [K-1:0] original;
    logic         good_syndrome;

    exp_t  exp_q[$];
    string name_q[$];
    int    passed = 0;
    int    total  = 0;

    always #5 clk = ~clk;

    vt_decoder #(
        .k           (K),
        .n           (N),
        .SYNDROME_VAL(A)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .original     (original),
        .good_syndrome(good_syndrome)
    );

    // Reference model. It computes the weighted sum and residue, applies
    // the 1->0 repair if enabled, and reads data bits from the
    // non-power-of-two positions.
    function automatic exp_t ref_model(input logic [N-1:0] w);
        int           sum;
        int           syn;
        int           p;
        int           cnt;
        logic [N-1:0] fixed;
        exp_t         e;
        sum = 0;
        for (int i = 1; i <= N; i++) begin
            if (w[i-1]) sum += i;
        end
        syn    = sum % (N + 1);
        e.good = (syn == A);
        fixed  = w;
`ifdef VT_ASYM_CORRECT_EN
        if (syn != A) begin
            p = (A - syn + N + 1) % (N + 1);
            if (p >= 1 && p <= N && fixed[p-1] == 1'b0) fixed[p-1] = 1'b1;
        end
`else
        p = 0;
`endif
        cnt    = 0;
        e.orig = '0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt < K) e.orig[cnt] = fixed[i-1];
                cnt++;
            end
        end
        return e;
    endfunction

    // Reference encoder. It places the data bits, then picks the parity bits
    // so that the total residue equals A.
    function automatic logic [N-1:0] encode(input logic [K-1:0] d);
        logic [N-1:0] w;
        int           cnt;
        int           sum;
        int           r;
        w   = '0;
        cnt = 0;
        sum = 0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt < K) w[i-1] = d[cnt];
                cnt++;
            end
        end
        for (int i = 1; i <= N; i++) begin
            if (w[i-1]) sum += i;
        end
        r = (A - (sum % (N + 1)) + N + 1) % (N + 1);
        for (int b = 0; (1 << b) <= N; b++) begin
            if ((r >> b) & 1) w[(1 << b) - 1] = 1'b1;
        end
        return w;
    endfunction

    // Compare the DUT outputs against one expected response.
    task automatic check_output(input string name, input exp_t e);
        total++;
        if (original === e.orig && good_syndrome === e.good) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got original=%b good_syndrome=%b, expected original=%b good_syndrome=%b",
                     name, original, good_syndrome, e.orig, e.good);
        end
    endtask

    // Drive one word on the falling edge and queue its expected response.
    task automatic apply_stimulus(input logic [N-1:0] w, input exp_t e, input string name);
        @(negedge clk);
        data_in = w;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: just after each rising edge, pop and compare if a response is due.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check_output(nm, e);
            end
        end
    end

    // Stimulus: directed vectors, asynchronous reset, back-to-back words, then
    // random traffic.
    initial begin
        logic [N-1:0] cw1;
        logic [N-1:0] cw2;
        logic [N-1:0] w;
        logic [K-1:0] d;
        int           mode;
        int           bit_idx;
        int           guard;

        cw1     = 10'b0111010101;
        cw2     = 10'b0110110110;
        rst_n   = 1'b1;
        data_in = '0;
        #1 rst_n = 1'b0;
        #2 check_output("reset_init", '{orig: 5'b00000, good: 1'b0});
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        apply_stimulus(cw1, '{orig: 5'b11011, good: 1'b1}, "clean1");
        apply_stimulus(cw2, '{orig: 5'b10111, good: 1'b1}, "clean2");
`ifdef VT_ASYM_CORRECT_EN
        apply_stimulus(10'b0011010101, '{orig: 5'b11011, good: 1'b0}, "asym_err");
`else
        apply_stimulus(10'b0011010101, '{orig: 5'b01011, good: 1'b0}, "asym_err");
`endif
        apply_stimulus(10'b0111010111, '{orig: 5'b11011, good: 1'b0}, "uncorrectable");

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) apply_stimulus(cw1, '{orig: 5'b11011, good: 1'b1}, "b2b_cw1");
            else            apply_stimulus(cw2, '{orig: 5'b10111, good: 1'b1}, "b2b_cw2");
        end

        // Assert reset mid-cycle. The outputs must clear without waiting for
        // an edge. An edge taken while reset is held must discard its input.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_output("async_reset", '{orig: 5'b00000, good: 1'b0});
        apply_stimulus(cw2, '{orig: 5'b00000, good: 1'b0}, "reset_held");
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply_stimulus(cw2, '{orig: 5'b10111, good: 1'b1}, "after_release");

        for (int i = 0; i < 300; i++) begin
            d    = K'($urandom);
            w    = encode(d);
            mode = $urandom_range(0, 3);
            if (mode == 1 && w != '0) begin
                do bit_idx = $urandom_range(0, N - 1); while (w[bit_idx] == 1'b0);
                w[bit_idx] = 1'b0;
            end else if (mode == 2) begin
                w = N'($urandom);
            end else if (mode == 3) begin
                w[$urandom_range(0, N - 1)] = 1'b1;
            end
            apply_stimulus(w, ref_model(w), "random");
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("[TB] FAIL drain: %0d responses still pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
